score_log_controller: RTL and testbench

//  Sequences the single-port score RAM and the high-score register for the dino game.

---
 rtl/score_pkg.sv | 15 +
 rtl/score_log_ptr.sv | 31 +++
 rtl/score_log_controller.sv | 127 ++++++++++++
 tb/tb_score_log_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score log: controller state encoding and default sizes.
package score_pkg;
    localparam int DEPTH_DEF  = 512;
    localparam int DATA_W_DEF = 32;
    localparam int SCORE_W    = DATA_W_DEF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_RESP = 3'd4,
        S_CLEAR   = 3'd5
    } state_t;
endpackage

// File: rtl/score_log_ptr.sv
// Circular-log bookkeeping: head pointer, saturating occupancy count and
// the RAM address of the entry rd_index places back from the newest.
module score_log_ptr #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] rd_index,
    output logic [ADDR_W-1:0] head,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rd_addr
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            head  <= '0;
            count <= '0;
        end else if (inc) begin
            head <= head + 1'b1;
            if (count != FULL)
                count <= count + 1'b1;
        end
    end

    // head points at the next free slot, so the newest entry sits at head-1
    assign rd_addr = head - ADDR_W'(1) - rd_index;
endmodule

// File: rtl/score_log_controller.sv
// Arbitrates the single-port score RAM between append, read-back and clear,
// and tracks the running high score.
module score_log_controller
    import score_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_score,
    output logic              wr_ack,
    output logic              hs_new,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_index,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_miss,
    input  logic              clear_req,
    output logic              busy,
    output logic [DATA_W-1:0] high_score,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] head, rd_addr, sweep, addr_q;
    logic              hit, clr;

    assign hit  = ({1'b0, rd_index} < count);
    assign clr  = (state == S_IDLE) && clear_req;
    assign busy = (state != S_IDLE);

    score_log_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .inc      (wr_ack),
        .rd_index (rd_index),
        .head     (head),
        .count    (count),
        .rd_addr  (rd_addr)
    );

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = '0;
        wr_ack    = 1'b0;
        hs_new    = 1'b0;
        rd_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear_req)   state_nxt = S_CLEAR;
                else if (wr_req) state_nxt = S_WRITE;
                else if (rd_req) state_nxt = hit ? S_RD_ADDR : S_RD_RESP;
            end
            S_WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = head;
                ram_wdata = wr_score;
                wr_ack    = 1'b1;
                hs_new    = (wr_score > high_score);
                state_nxt = S_IDLE;
            end
            S_RD_ADDR: begin
                ram_addr  = rd_addr;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: state_nxt = S_RD_RESP;
            S_RD_RESP: begin
                rd_valid  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = sweep;
                if (sweep == ADDR_W'(DEPTH - 1))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // a reset cycle must never disturb the RAM or emit a pulse
        if (reset) begin
            ram_we   = 1'b0;
            ram_addr = '0;
            wr_ack   = 1'b0;
            hs_new   = 1'b0;
            rd_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            high_score <= '0;
            rd_data    <= '0;
            rd_miss    <= 1'b0;
            sweep      <= '0;
            addr_q     <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= ram_addr;
            if (hs_new)
                high_score <= wr_score;
            if (clr) begin
                high_score <= '0;
                sweep      <= '0;
            end
            if (state == S_CLEAR)
                sweep <= sweep + 1'b1;
            if (state == S_IDLE && state_nxt == S_RD_RESP) begin
                rd_data <= '0;
                rd_miss <= 1'b1;
            end
            if (state == S_IDLE && state_nxt == S_RD_ADDR)
                rd_miss <= 1'b0;
            if (state == S_RD_WAIT)
                rd_data <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_score_log_controller.sv
// Directed + randomized bench: a queue-based log model and a behavioural RAM.
module tb_score_log_controller;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset, wr_req, rd_req, clear_req;
    logic [DW-1:0] wr_score, rd_data, high_score, ram_wdata, ram_rdata;
    logic [AW-1:0] rd_index, ram_addr;
    logic [AW:0]   count;
    logic          wr_ack, hs_new, rd_valid, rd_miss, busy, ram_we;

    logic [DW-1:0] mem [DEPTH];

    int unsigned q[$];
    logic [DW-1:0] hs_m;
    int head_m;
    int nerr = 0, nchk = 0;

    always #5 clk = ~clk;

    score_log_controller dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_score(wr_score), .wr_ack(wr_ack),
        .hs_new(hs_new), .rd_req(rd_req), .rd_index(rd_index), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_miss(rd_miss), .clear_req(clear_req), .busy(busy),
        .high_score(high_score), .count(count), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hs_m   = '0;
        head_m = 0;
    endtask

    task automatic model_write(input logic [DW-1:0] s);
        if (s > hs_m) hs_m = s;
        q.push_back(s);
        if (q.size() > DEPTH) void'(q.pop_front());
        head_m = (head_m + 1) % DEPTH;
    endtask

    task automatic do_write(input logic [DW-1:0] s);
        int n = 0;
        bit got = 0;
        wr_req = 1'b1; wr_score = s;
        while (n < 40 && !got) begin
            @(negedge clk); n++;
            if (wr_ack) begin
                got = 1;
                chk("hs_new", hs_new, s > hs_m);
                chk("wr_we", ram_we, 1'b1);
                chk("wr_addr", ram_addr, head_m[AW-1:0]);
                chk("wr_wdata", ram_wdata, s);
            end
        end
        chk("wr_ack_seen", got, 1'b1);
        wr_req = 1'b0;
        model_write(s);
        @(negedge clk);
        chk("count", count, q.size());
        chk("high_score", high_score, hs_m);
    endtask

    task automatic do_read(input int idx);
        int n = 0;
        bit got = 0, we_seen = 0, miss;
        logic [DW-1:0] exp;
        miss = (idx >= q.size());
        exp  = miss ? '0 : q[q.size() - 1 - idx];
        rd_req = 1'b1; rd_index = AW'(idx);
        while (n < 20 && !got) begin
            @(negedge clk); n++;
            if (ram_we) we_seen = 1;
            if (rd_valid) begin
                got = 1;
                chk("rd_data", rd_data, exp);
                chk("rd_miss", rd_miss, miss);
                chk("rd_latency", n, miss ? 1 : 3);
            end
        end
        chk("rd_valid_seen", got, 1'b1);
        chk("rd_no_we", we_seen, 1'b0);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busyc;
        bit ok, got, pulse;
        logic [DW-1:0] s;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        reset = 1'b1; wr_req = 0; rd_req = 0; clear_req = 0; wr_score = 0; rd_index = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_hs", high_score, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_pulses", {wr_ack, hs_new, rd_valid}, 3'b000);
        reset = 1'b0;
        @(negedge clk);

        // empty log read is a miss
        do_read(0);

        // small append / readback
        do_write(5); do_write(9); do_write(3);
        chk("count3", count, 3);
        chk("hs9", high_score, 9);
        do_read(0); do_read(1); do_read(2); do_read(3);

        // fill past capacity so the log wraps and count saturates
        for (int i = 1; i <= DEPTH + 2; i++) do_write(DW'(i));
        chk("count_sat", count, DEPTH);
        do_read(0); do_read(511); do_read(200);

        // write wins over a simultaneous read, read then sees it
        s = 32'd77;
        wr_req = 1; wr_score = s; rd_req = 1; rd_index = 0;
        @(negedge clk);
        chk("prio_wr_ack", wr_ack, 1'b1);
        chk("prio_no_rd", rd_valid, 1'b0);
        wr_req = 0;
        model_write(s);
        n = 0; got = 0;
        while (n < 10 && !got) begin
            @(negedge clk); n++;
            if (rd_valid) begin
                got = 1;
                chk("prio_rd_data", rd_data, s);
            end
        end
        chk("prio_rd_seen", got, 1'b1);
        rd_req = 0;
        @(negedge clk);

        // clear with a write raised mid-sweep and a stray clear pulse
        do_write(1000); do_write(12);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        busyc = 0; ok = 1; s = 32'd42;
        while (busy && busyc < DEPTH + 10) begin
            if (!(ram_we && ram_addr == AW'(busyc) && ram_wdata == 0)) ok = 0;
            busyc++;
            if (busyc == 10) begin wr_req = 1; wr_score = s; end
            clear_req = (busyc == 50);
            @(negedge clk);
        end
        clear_req = 0;
        chk("clr_busy_cycles", busyc, DEPTH);
        chk("clr_sweep", ok, 1'b1);
        chk("clr_count", count, 0);
        chk("clr_hs", high_score, 0);
        model_reset();
        n = 0; got = 0;
        while (n < 5 && !got) begin
            @(negedge clk); n++;
            if (wr_ack) begin
                got = 1;
                chk("clr_wr_addr", ram_addr, 0);
                chk("clr_hs_new", hs_new, 1'b1);
            end
        end
        chk("clr_wr_seen", got, 1'b1);
        wr_req = 0;
        model_write(s);
        @(negedge clk);
        chk("clr_count1", count, 1);
        chk("clr_hs_new_val", high_score, s);
        ok = 1;
        for (int i = 1; i < DEPTH; i++) if (mem[i] !== 0) ok = 0;
        chk("clr_mem_zero", ok, 1'b1);
        chk("clr_mem0", mem[0], s);

        // randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 1) == 1) do_write($urandom_range(0, 5000));
            else do_read($urandom_range(0, q.size() + 2));
        end

        // reset while waiting for RAM data
        do_write(31);
        rd_req = 1; rd_index = 0;
        @(negedge clk); @(negedge clk);
        chk("rw_busy", busy, 1'b1);
        reset = 1; rd_req = 0;
        @(negedge clk);
        reset = 0;
        model_reset();
        chk("rw_busy0", busy, 1'b0);
        chk("rw_count", count, 0);
        chk("rw_hs", high_score, 0);
        pulse = rd_valid;
        repeat (4) begin @(negedge clk); pulse |= rd_valid; end
        chk("rw_no_valid", pulse, 1'b0);

        // reset partway through a clear sweep
        do_write(88); do_write(99);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        n = 0;
        while (ram_addr != 100 && n < DEPTH) begin @(negedge clk); n++; end
        chk("rc_reach100", ram_addr, 100);
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
        chk("rc_busy0", busy, 1'b0);
        chk("rc_count", count, 0);
        chk("rc_hs", high_score, 0);
        @(negedge clk);
        chk("rc_idle", busy, 1'b0);
        do_read(0);
        do_write(7);
        do_read(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
